// File: rtl/uart_rx_core.sv
// Oversampled UART receiver core: RTS-gated start detection, mid-bit sampling,
// 5..MAX_DATA_BITS data bits, optional parity, one or two stop bits, and
// parity/frame/break reporting on a one-clock data_valid_o pulse.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_en_i,
  input  logic                     rts_ni,
  input  logic                     rx_i,
  input  logic                     baud_tick_i,
  input  logic [3:0]               data_bits_i,
  input  logic [2:0]               parity_mode_i,
  input  logic                     stop_bits_i,
  output logic [MAX_DATA_BITS-1:0] data_o,
  output logic                     data_valid_o,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     break_o,
  output logic                     busy_o
);

  localparam int              CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]      MAX_N     = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, RTS_WAIT, SCAN, START, DATA, PARITY, STOP, FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            tick_q;
  logic [3:0]               bit_q;
  logic [3:0]               n_q;
  logic [2:0]               par_q;
  logic                     stop2_q;
  logic [MAX_DATA_BITS-1:0] shift_q;
  logic                     xor_q, zero_q, perr_q, ferr_q;

  logic sample, in_frame, par_en, last_data, last_stop, exp_par;

  // Out-of-range widths are pulled into the supported 5..MAX_DATA_BITS window.
  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'd5)       return 4'd5;
    else if (b > MAX_N) return MAX_N;
    else                return b;
  endfunction

  // START samples half a bit in; later states sample once per full bit period.
  assign sample    = baud_tick_i &&
                     (tick_q == ((state_q == START) ? MID_TICK : LAST_TICK));
  assign in_frame  = state_q inside {START, DATA, PARITY, STOP};
  assign par_en    = par_q inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign last_data = (bit_q == n_q - 4'd1);
  assign last_stop = (bit_q == {3'b000, stop2_q});

  assign data_valid_o = (state_q == FINISH);
  assign busy_o       = state_q inside {START, DATA, PARITY, STOP, FINISH};

  // Expected parity bit from the running XOR of the data bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    exp_par = 1'b0;
    case (par_q)
      3'd1:    exp_par = xor_q;
      3'd2:    exp_par = ~xor_q;
      3'd3:    exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it is tested only inside the clocked branch.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; enable and RTS only gate frame starts, never abort a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_en_i) state_d = RTS_WAIT;
      RTS_WAIT: if (!rts_ni)       state_d = SCAN;
                else if (!rx_en_i) state_d = IDLE;
      SCAN:     if (rts_ni)        state_d = RTS_WAIT;
                else if (!rx_en_i) state_d = IDLE;
                else if (!rx_i)    state_d = START;
      START:    if (sample) state_d = rx_i ? SCAN : DATA;
      DATA:     if (sample && last_data) state_d = par_en ? PARITY : STOP;
      PARITY:   if (sample) state_d = STOP;
      STOP:     if (sample && last_stop) state_d = FINISH;
      FINISH:   if (rx_en_i && !rts_ni && !rx_i) state_d = START;
                else if (rx_en_i && !rts_ni)     state_d = SCAN;
                else if (rx_en_i)                state_d = RTS_WAIT;
                else                             state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Tick/bit counters, configuration latch, data shift-in and result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      tick_q       <= '0;
      bit_q        <= '0;
      n_q          <= '0;
      par_q        <= '0;
      stop2_q      <= 1'b0;
      shift_q      <= '0;
      xor_q        <= 1'b0;
      zero_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      // A tick arriving on the entry clock already belongs to START.
      if (state_d == START && state_q != START)
        tick_q <= baud_tick_i ? CW'(1) : '0;
      else if (in_frame && sample)
        tick_q <= '0;
      else if (in_frame && baud_tick_i)
        tick_q <= tick_q + 1'b1;

      case (state_q)
        START: if (sample && !rx_i) begin
          n_q     <= clamp_bits(data_bits_i);
          par_q   <= parity_mode_i;
          stop2_q <= stop_bits_i;
          bit_q   <= '0;
          shift_q <= '0;
          xor_q   <= 1'b0;
          zero_q  <= 1'b1;
          perr_q  <= 1'b0;
          ferr_q  <= 1'b0;
        end
        DATA: if (sample) begin
          shift_q <= {rx_i, shift_q[MAX_DATA_BITS-1:1]};
          xor_q   <= xor_q ^ rx_i;
          zero_q  <= zero_q & ~rx_i;
          bit_q   <= last_data ? 4'd0 : bit_q + 4'd1;
        end
        PARITY: if (sample) begin
          perr_q <= rx_i ^ exp_par;
          zero_q <= zero_q & ~rx_i;
        end
        STOP: if (sample) begin
          bit_q <= bit_q + 4'd1;
          if (!rx_i)        ferr_q <= 1'b1;
          if (bit_q == 4'd0) zero_q <= zero_q & ~rx_i;
          if (last_stop) begin
            // Bits entered at the top; shift the N received bits down to bit 0.
            data_o       <= shift_q >> (MAX_N - n_q);
            parity_err_o <= perr_q;
            frame_err_o  <= ferr_q | ~rx_i;
            break_o      <= (bit_q == 4'd0) ? (zero_q & ~rx_i) : zero_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized
// frames compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int OS       = 16;
  localparam int MDB      = 9;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_en_i = 1'b0;
  logic       rts_ni = 1'b1;
  logic       rx_i = 1'b1;
  logic       baud_tick_i = 1'b0;
  logic [3:0] data_bits_i = 4'd8;
  logic [2:0] parity_mode_i = 3'd0;
  logic       stop_bits_i = 1'b0;
  logic [MDB-1:0] data_o;
  logic       data_valid_o, parity_err_o, frame_err_o, break_o, busy_o;

  uart_rx_core #(.OVERSAMPLE(OS), .MAX_DATA_BITS(MDB)) dut (
    .clk(clk), .reset_n(reset_n), .rx_en_i(rx_en_i), .rts_ni(rts_ni),
    .rx_i(rx_i), .baud_tick_i(baud_tick_i), .data_bits_i(data_bits_i),
    .parity_mode_i(parity_mode_i), .stop_bits_i(stop_bits_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .break_o(break_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock wide, every TICK_DIV clocks, changed on the falling edge.
  int div = 0;
  always @(negedge clk) begin
    div = (div + 1) % TICK_DIV;
    baud_tick_i = (div == 0);
  end

  typedef struct { logic [MDB-1:0] data; logic pe, fe, brk; } frame_t;
  frame_t rxq[$];
  int pulse_cnt = 0;

  // Record every data_valid_o pulse together with its result fields.
  always @(negedge clk) begin
    if (data_valid_o === 1'b1) begin
      pulse_cnt++;
      rxq.push_back('{data_o, parity_err_o, frame_err_o, break_o});
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return just after a rising edge on which baud_tick_i was high.
  task automatic wait_tick();
    do @(posedge clk); while (baud_tick_i !== 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".data"},  16'(data_o), 16'h0);
    check({tag, ".valid"}, 16'(data_valid_o), 16'h0);
    check({tag, ".pe"},    16'(parity_err_o), 16'h0);
    check({tag, ".fe"},    16'(frame_err_o), 16'h0);
    check({tag, ".brk"},   16'(break_o), 16'h0);
    check({tag, ".busy"},  16'(busy_o), 16'h0);
  endtask

  // Build a frame from the line rules, drive it, and check the one result pulse.
  task automatic send_frame(input logic [8:0] data, input logic [3:0] nb_raw,
                            input logic [2:0] pm, input logic s2, input logic pflip,
                            input logic st1, input logic st2, input logic aligned,
                            input logic truncate, input logic scramble, input string tag);
    int n, cnt0, ticks;
    logic pen, pbit, exp_pe, exp_fe, exp_brk;
    logic [8:0] d;
    logic bits[$];
    n    = (nb_raw < 5) ? 5 : ((int'(nb_raw) > MDB) ? MDB : int'(nb_raw));
    pen  = (pm >= 3'd1 && pm <= 3'd4);
    d    = data & 9'((1 << n) - 1);
    case (pm)
      3'd1:    pbit = ^d;
      3'd2:    pbit = ~^d;
      3'd3:    pbit = 1'b1;
      default: pbit = 1'b0;
    endcase
    pbit = pbit ^ pflip;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(st1);
    if (s2) bits.push_back(st2);
    exp_pe  = pen & pflip;
    exp_fe  = !st1 || (s2 && !st2);
    exp_brk = (d == 9'd0) && (!pen || !pbit) && !st1;

    data_bits_i = nb_raw; parity_mode_i = pm; stop_bits_i = s2;
    cnt0 = pulse_cnt;
    if (!aligned) wait_tick();
    for (int k = 0; k < bits.size(); k++) begin
      ticks = (k == bits.size() - 1) ? OS / 2 : OS;
      #1 rx_i = bits[k];
      if (k == 0 && aligned) begin
        @(negedge clk);
        check({tag, ".direct_start"}, 16'(busy_o), 16'h1);
      end
      if (k == 0 && scramble) begin
        repeat (OS / 2) wait_tick();
        #1;
        data_bits_i = 4'($urandom); parity_mode_i = 3'($urandom);
        stop_bits_i = 1'($urandom); rx_en_i = 1'($urandom); rts_ni = 1'($urandom);
        repeat (OS / 2) wait_tick();
      end else begin
        repeat (ticks) wait_tick();
      end
    end
    @(negedge clk);
    check({tag, ".valid"}, 16'(data_valid_o), 16'h1);
    check({tag, ".data"},  16'(data_o), 16'(d));
    check({tag, ".pe"},    16'(parity_err_o), 16'(exp_pe));
    check({tag, ".fe"},    16'(frame_err_o), 16'(exp_fe));
    check({tag, ".brk"},   16'(break_o), 16'(exp_brk));
    #1;
    check({tag, ".pulses"}, 16'(pulse_cnt - cnt0), 16'h1);
    rx_en_i = 1'b1; rts_ni = 1'b0;
    if (!truncate) begin
      rx_i = 1'b1;
      repeat (OS / 2) wait_tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    logic ok;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1; rx_en_i = 1'b1; rts_ni = 1'b0;
    repeat (4) @(posedge clk);

    // 8N1 0xA5 and 7E1 0x41 with a wrong parity bit.
    send_frame(9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "8N1_A5");
    send_frame(9'h041, 4'd7, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "7E1_41");

    // False start: four ticks low, then high.
    c0 = pulse_cnt;
    wait_tick();
    #1 rx_i = 1'b0;
    repeat (4) wait_tick();
    #1 rx_i = 1'b1;
    repeat (20) wait_tick();
    @(negedge clk);
    check("false_start.busy", 16'(busy_o), 16'h0);
    check("false_start.pulses", 16'(pulse_cnt - c0), 16'h0);
    send_frame(9'h03C, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "8N1_3C");

    // Break: line low for 20 bit periods, then idle long enough to drain.
    data_bits_i = 4'd8; parity_mode_i = 3'd0; stop_bits_i = 1'b0;
    rxq.delete();
    wait_tick();
    #1 rx_i = 1'b0;
    repeat (20 * OS) wait_tick();
    #1 rx_i = 1'b1;
    repeat (200) wait_tick();
    check("break.count", 16'(rxq.size() >= 2), 16'h1);
    for (int i = 0; i < 2 && i < rxq.size(); i++) begin
      check($sformatf("break%0d.data", i), 16'(rxq[i].data), 16'h0);
      check($sformatf("break%0d.pe", i),   16'(rxq[i].pe), 16'h0);
      check($sformatf("break%0d.fe", i),   16'(rxq[i].fe), 16'h1);
      check($sformatf("break%0d.brk", i),  16'(rxq[i].brk), 16'h1);
    end

    // Back-to-back 9O2 frames: second start bit begins at the stop sample.
    send_frame(9'h1FF, 4'd9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "9O2_1FF");
    send_frame(9'h100, 4'd9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "9O2_100");

    // RTS hold-off with a toggling line.
    rx_i = 1'b1; rts_ni = 1'b1;
    repeat (4) @(posedge clk);
    c0 = pulse_cnt; ok = 1'b1;
    for (int i = 0; i < 4 * OS; i++) begin
      wait_tick();
      #1 rx_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy_o !== 1'b0) ok = 1'b0;
    end
    check("rts_hold.idle", 16'(ok), 16'h1);
    check("rts_hold.pulses", 16'(pulse_cnt - c0), 16'h0);
    rx_i = 1'b1; rts_ni = 1'b0;
    repeat (4) @(posedge clk);

    // Randomized frames; configuration and enables scrambled mid-frame.
    for (int i = 0; i < 12; i++) begin
      send_frame(9'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 4) != 0), 1'b0, 1'b0, 1'b1,
                 $sformatf("rnd%0d", i));
    end

    // Reset during DATA.
    data_bits_i = 4'd8; parity_mode_i = 3'd0; stop_bits_i = 1'b0;
    wait_tick();
    #1 rx_i = 1'b0;
    repeat (OS) wait_tick();
    #1 rx_i = 1'b1;
    repeat (20) wait_tick();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    send_frame(9'h05A, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick_i pulses per bit period; it SHALL be even and at least 4.
REQ-002 The block SHALL have parameter MAX_DATA_BITS, default 9, meaning the widest supported data field (5..9).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- rx_en_i  in  1  receiver enable
- rts_ni  in  1  request-to-send, active-low; high = hold off
- rx_i  in  1  serial line, already synchronised to clk, idle high
- baud_tick_i  in  1  oversample strobe, one clk wide
- data_bits_i  in  4  data bits per frame (5..MAX_DATA_BITS)
- parity_mode_i  in  3  parity: 0 none, 1 even, 2 odd, 3 mark, 4 space; 5-7 treated as none
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
- data_o  out  MAX_DATA_BITS  received word, right-aligned
- data_valid_o  out  1  one-clk pulse, frame complete
- parity_err_o  out  1  parity mismatch, qualified by data_valid_o
- frame_err_o  out  1  stop bit sampled low, qualified by data_valid_o
- break_o  out  1  break detected, qualified by data_valid_o
- busy_o  out  1  frame in progress (START..FINISH)

Function
REQ-004 The FSM SHALL have the states IDLE, RTS_WAIT, SCAN, START, DATA, PARITY, STOP and FINISH.
REQ-005 State transitions SHALL be:
- IDLE -> RTS_WAIT when rx_en_i=1.
- RTS_WAIT -> SCAN when rts_ni=0; RTS_WAIT -> IDLE when rx_en_i=0.
- SCAN -> RTS_WAIT when rts_ni=1; else SCAN -> IDLE when rx_en_i=0; else SCAN -> START when rx_i=0.
REQ-006 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide, clear on entry to START, and advance only on baud_tick_i.
REQ-007 In START, the block SHALL sample rx_i at tick OVERSAMPLE/2-1 (mid-bit):
- rx_i=1: false start; return to SCAN with no output change.
- rx_i=0: go to DATA and reset the counter.
REQ-008 In DATA, PARITY and STOP, one sample SHALL be taken every OVERSAMPLE ticks, aligned to mid-bit.
REQ-009 Data SHALL be received LSB first. data_o[N-1:0] holds the received bits, where N is the effective data width; data_o bits above N SHALL be 0.
REQ-010 The effective N SHALL be clamped: data_bits_i<5 gives 5; data_bits_i>MAX_DATA_BITS gives MAX_DATA_BITS.
REQ-011 data_bits_i, parity_mode_i and stop_bits_i SHALL be latched on the START->DATA transition; changes mid-frame SHALL have no effect on that frame.
REQ-012 After N data samples the FSM SHALL go to PARITY if parity is enabled, else to STOP.
REQ-013 Expected parity SHALL be:
- even: XOR of the data bits.
- odd: inverted XOR of the data bits.
- mark: 1.
- space: 0.
REQ-014 parity_err SHALL be set when the parity sample differs from expected parity, and SHALL be 0 when parity is none.
REQ-015 STOP SHALL take 1 or 2 samples per the latched stop_bits. frame_err SHALL be set if any stop sample is 0.
REQ-016 break SHALL be set when all data bits, the parity bit (if present) and the first stop sample are 0. break implies frame_err.
REQ-017 After the last stop sample the FSM SHALL enter FINISH for exactly one clk. In FINISH:
- data_valid_o=1.
- data_o and the error flags are stable from the FINISH clk until the next FINISH.
REQ-018 FINISH SHALL exit as follows:
- -> START if rx_en_i=1, rts_ni=0 and rx_i=0;
- else -> SCAN if rx_en_i=1 and rts_ni=0;
- else -> RTS_WAIT if rx_en_i=1;
- else -> IDLE.
REQ-019 rx_en_i=0 or rts_ni=1 during START..STOP SHALL NOT abort the frame; it takes effect at FINISH.
REQ-020 baud_tick_i coinciding with a state transition SHALL be counted in the new state; ticks are never lost or double-counted.
REQ-021 busy_o SHALL be 1 in START, DATA, PARITY, STOP and FINISH, and 0 otherwise.

Reset
REQ-022 reset_n=0 at a clock edge SHALL force IDLE from any state, including mid-frame, and SHALL clear:
- data_o to 0;
- data_valid_o, parity_err_o, frame_err_o, break_o and busy_o to 0;
- the tick and bit counters and the latched configuration.
REQ-023 The first frame after reset release SHALL require the IDLE->RTS_WAIT->SCAN path before any start bit is accepted.

Verification
REQ-024 The bench SHALL cover: OVERSAMPLE=16, 8N1, byte 0xA5 -> data_o=0x0A5, one data_valid_o pulse one clk after the stop sample, all error flags 0.
REQ-025 The bench SHALL cover: 7E1, data 0x41 sent with parity bit 1 -> data_o=0x041, parity_err_o=1, frame_err_o=0.
REQ-026 The bench SHALL cover: rx_i low for 4 ticks then high -> return to SCAN, no data_valid_o; a following 0x3C frame is received correctly.
REQ-027 The bench SHALL cover: 8N1, line held low for 20 bit periods -> frame_err_o=1, break_o=1, data_o=0x000.
REQ-028 The bench SHALL cover: 9O2 frame 0x1FF sent back-to-back with a second 9O2 frame 0x100 -> two data_valid_o pulses with the correct values; FINISH goes directly to START for the second frame.
REQ-029 The bench SHALL cover two abort/hold-off cases:
- rts_ni=1 with rx_i toggling -> FSM held in RTS_WAIT, no data_valid_o.
- reset_n=0 during DATA -> IDLE with all outputs 0 on the next clk.
